// File: rtl/offload_frame_packer_if.sv
// AXI-Stream bundle shared by the packer's 64-bit input and 512-bit output.
// The instantiating level picks the data width; keep is one bit per byte.
interface offload_frame_packer_if #(
    parameter int DATA_W = 64
);
    localparam int KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/offload_frame_packer.sv
// Packs eight 64-bit DMA beats into one 512-bit frame, checks it (full keep,
// magic word in word 15, no early tlast) and forwards only good frames through
// a single-entry output buffer. Dropped frames bump a saturating counter.
module offload_frame_packer #(
    parameter logic [31:0] PKT_MAGIC = 32'h0FFA_0FFB,
    parameter int          ERR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    offload_frame_packer_if.slave  s_axis,   // 64-bit beats from the DMA
    offload_frame_packer_if.master m_axis,   // 512-bit frames to the offload core
    output logic [ERR_WIDTH-1:0]   err_count,
    output logic [3:0]             dbg
);

    // Beats 0..6 are held here; beat 7 goes straight into the output register
    // together with this assembly, so only 7 beats of storage are needed.
    logic [447:0]          asm_q, asm_d;
    logic [2:0]            idx_q, idx_d;
    logic                  bad_q, bad_d;
    logic [511:0]          out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic                  drop_q, drop_d;

    logic s_ready;
    logic beat_ok;
    logic closing;
    logic early_last;
    logic keep_bad;
    logic frame_good;

    // Next-state logic: beat acceptance, frame close/validation, output buffer, drop count.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        idx_d       = idx_q;
        bad_d       = bad_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = err_q;
        drop_d      = drop_q;

        // Only the closing beat can be held off by a full output buffer.
        s_ready    = reset_n && (idx_q != 3'd7 || !out_valid_q || m_axis.tready);
        beat_ok    = s_axis.tvalid && s_ready;
        closing    = beat_ok && (idx_q == 3'd7);
        early_last = beat_ok && (idx_q != 3'd7) && s_axis.tlast;
        keep_bad   = (s_axis.tkeep != 8'hFF);
        frame_good = !bad_q && !keep_bad && (s_axis.tdata[63:32] == PKT_MAGIC);

        if (beat_ok) begin
            if (idx_q != 3'd7) begin
                asm_d[{idx_q, 6'd0} +: 64] = s_axis.tdata;
            end
            idx_d = idx_q + 3'd1;
            bad_d = bad_q || keep_bad;
        end

        // A short transfer abandons the partial frame and realigns to beat 0.
        if (early_last) begin
            idx_d = 3'd0;
            bad_d = 1'b0;
        end

        if (closing) begin
            bad_d = 1'b0;
        end

        // Handshake empties the buffer; a frame closing in the same cycle refills it.
        if (out_valid_q && m_axis.tready) begin
            out_valid_d = 1'b0;
        end
        if (closing && frame_good) begin
            out_valid_d = 1'b1;
            out_data_d  = {s_axis.tdata, asm_q};
            out_last_d  = s_axis.tlast;
            drop_d      = 1'b0;
        end
        if (closing && !frame_good) begin
            drop_d = 1'b1;
        end

        if (((closing && !frame_good) || early_last) && (err_q != '1)) begin
            err_d = err_q + ERR_WIDTH'(1);
        end
    end

    // Control and output state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            idx_q       <= 3'd0;
            bad_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= '0;
            drop_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            bad_q       <= bad_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    // Assembly datapath register.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; every slot is rewritten before a frame can close and read it.
        asm_q <= asm_d;
    end

    // Output mapping.
    always_comb begin
        s_axis.tready = s_ready;
        m_axis.tvalid = out_valid_q;
        m_axis.tdata  = out_data_q;
        m_axis.tlast  = out_last_q;
        m_axis.tkeep  = {64{out_valid_q}};
        err_count     = err_q;
        dbg           = {(err_q != '0), drop_q, out_valid_q, (idx_q != 3'd0)};
    end

endmodule

// File: tb/tb_offload_frame_packer.sv
// Directed bench for offload_frame_packer: good frame, bad magic, early tlast,
// bad keep plus output backpressure, counter saturation and mid-frame reset.
module tb_offload_frame_packer;

    localparam logic [31:0] MAGIC = 32'h0FFA_0FFB;
    localparam logic [31:0] BADMG = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] err_count;
    logic [3:0]  dbg;

    offload_frame_packer_if #(.DATA_W(64))  s_if ();
    offload_frame_packer_if #(.DATA_W(512)) m_if ();

    offload_frame_packer #(.PKT_MAGIC(MAGIC), .ERR_WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .err_count (err_count),
        .dbg       (dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beat k of a frame with the given seed: word 2k = seed+2k, word 2k+1 = seed+2k+1.
    function automatic logic [63:0] beat_of(input logic [31:0] seed, input int k, input logic [31:0] top);
        if (k == 7) return {top, seed + 32'd14};
        return {seed + 32'(2 * k + 1), seed + 32'(2 * k)};
    endfunction

    // Expected 512-bit frame: word n = seed+n for n<15, word 15 = magic.
    function automatic logic [511:0] frame_of(input logic [31:0] seed);
        logic [511:0] f;
        f = '0;
        for (int n = 0; n < 15; n++) f[32 * n +: 32] = seed + 32'(n);
        f[511:480] = MAGIC;
        return f;
    endfunction

    // Present one beat and return #1 after the edge that accepted it.
    task automatic send_beat(input logic [63:0] data, input logic [7:0] keep, input logic last);
        int guard;
        guard = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = data;
        s_if.tkeep  = keep;
        s_if.tlast  = last;
        @(negedge clk);
        while (!s_if.tready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("tready_timeout", 512'(s_if.tready), 512'(1'b1));
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // Send beats 0..7; keep_beat gets tkeep 0F; tlast on last_beat (stop there if < 7).
    task automatic send_frame(input logic [31:0] seed, input logic [31:0] top,
                              input int keep_beat, input int last_beat);
        for (int k = 0; k < 8; k++) begin
            send_beat(beat_of(seed, k, top), (k == keep_beat) ? 8'h0F : 8'hFF, k == last_beat);
            if (k == last_beat) break;
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] seed, input logic last);
        check({tag, "_tvalid"}, 512'(m_if.tvalid), 512'(1'b1));
        check({tag, "_tdata"},  m_if.tdata, frame_of(seed));
        check({tag, "_tlast"},  512'(m_if.tlast), 512'(last));
        check({tag, "_tkeep"},  512'(m_if.tkeep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_s_tready", 512'(s_if.tready), 512'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = 8'hFF;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        @(posedge clk);
        #1;

        // Step 1: reset state, then one good frame with tlast.
        do_reset();
        check("rst_tvalid", 512'(m_if.tvalid), 512'(1'b0));
        check("rst_tdata",  m_if.tdata, 512'(0));
        check("rst_err",    512'(err_count), 512'(16'h0));
        check("rst_dbg",    512'(dbg), 512'(4'h0));
        send_frame(32'h0, MAGIC, -1, 7);
        check_out("t1", 32'h0, 1'b1);
        check("t1_err", 512'(err_count), 512'(16'h0));
        @(posedge clk);
        #1;
        check("t1_consumed", 512'(m_if.tvalid), 512'(1'b0));

        // Step 2: bad magic is dropped, then a good frame clears the sticky drop flag.
        do_reset();
        send_frame(32'h0, BADMG, -1, 7);
        check("t2_no_valid", 512'(m_if.tvalid), 512'(1'b0));
        check("t2_err", 512'(err_count), 512'(16'h1));
        check("t2_dbg", 512'(dbg), 512'(4'b1100));
        send_frame(32'h40, MAGIC, -1, 7);
        check_out("t2_good", 32'h40, 1'b1);
        check("t2_dbg_clear", 512'(dbg), 512'(4'b1010));

        // Step 3: early tlast on beat 3, then an aligned good frame.
        do_reset();
        send_frame(32'h100, MAGIC, -1, 3);
        check("t3_err_early", 512'(err_count), 512'(16'h1));
        check("t3_no_valid", 512'(m_if.tvalid), 512'(1'b0));
        check("t3_idx0", 512'(dbg[0]), 512'(1'b0));
        send_frame(32'h200, MAGIC, -1, 7);
        check_out("t3_good", 32'h200, 1'b1);
        check("t3_err", 512'(err_count), 512'(16'h1));

        // Step 4: bad keep drop, then three frames against a stalled output.
        do_reset();
        m_if.tready = 1'b0;
        send_frame(32'h300, MAGIC, 5, 7);
        check("t4_err", 512'(err_count), 512'(16'h1));
        check("t4_no_valid", 512'(m_if.tvalid), 512'(1'b0));
        fork
            begin
                send_frame(32'h1000, MAGIC, -1, 7);
                send_frame(32'h2000, MAGIC, -1, 8);
                send_frame(32'h3000, MAGIC, -1, 7);
            end
            begin
                int g;
                logic [31:0] seeds [3];
                logic        lasts [3];
                seeds = '{32'h1000, 32'h2000, 32'h3000};
                lasts = '{1'b1, 1'b0, 1'b1};
                g = 0;
                while (!m_if.tvalid && g < 50) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                check_out("t4_A_first", 32'h1000, 1'b1);
                repeat (20) @(posedge clk);
                #1;
                check_out("t4_A_held", 32'h1000, 1'b1);
                check("t4_stall_tready", 512'(s_if.tready), 512'(1'b0));
                check("t4_stall_mid", 512'(dbg[0]), 512'(1'b1));
                m_if.tready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    g = 0;
                    @(negedge clk);
                    while (!m_if.tvalid && g < 50) begin
                        @(negedge clk);
                        g++;
                    end
                    check_out($sformatf("t4_out%0d", k), seeds[k], lasts[k]);
                    @(posedge clk);
                end
            end
        join
        #1;
        check("t4_err_final", 512'(err_count), 512'(16'h1));

        // Step 5: preload 65534 one-beat transfers, then saturate with bad frames.
        do_reset();
        m_if.tready = 1'b1;
        s_if.tdata  = '0;
        s_if.tkeep  = 8'hFF;
        s_if.tlast  = 1'b1;
        s_if.tvalid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        check("t5_preload", 512'(err_count), 512'(16'hFFFE));
        send_frame(32'h0, BADMG, -1, 7);
        check("t5_sat1", 512'(err_count), 512'(16'hFFFF));
        send_frame(32'h0, BADMG, -1, 7);
        send_frame(32'h0, BADMG, -1, 7);
        check("t5_sat3", 512'(err_count), 512'(16'hFFFF));
        check("t5_dbg", 512'(dbg), 512'(4'b1100));

        // Step 6: reset with a buffered frame and a half-built one, then a clean frame.
        m_if.tready = 1'b0;
        send_frame(32'h5000, MAGIC, -1, 7);
        check("t6_buffered", 512'(m_if.tvalid), 512'(1'b1));
        for (int k = 0; k < 4; k++) send_beat(beat_of(32'h5100, k, MAGIC), 8'hFF, 1'b0);
        check("t6_mid", 512'(dbg[0]), 512'(1'b1));
        reset_n = 1'b0;
        #1;
        check("t6_rst_tready", 512'(s_if.tready), 512'(1'b0));
        @(posedge clk);
        #1;
        check("t6_tvalid", 512'(m_if.tvalid), 512'(1'b0));
        check("t6_tdata",  m_if.tdata, 512'(0));
        check("t6_tlast",  512'(m_if.tlast), 512'(1'b0));
        check("t6_tkeep",  512'(m_if.tkeep), 512'(0));
        check("t6_err",    512'(err_count), 512'(16'h0));
        check("t6_dbg",    512'(dbg), 512'(4'h0));
        reset_n = 1'b1;
        m_if.tready = 1'b1;
        send_frame(32'h6000, MAGIC, -1, 7);
        check_out("t6_clean", 32'h6000, 1'b1);
        check("t6_err_after", 512'(err_count), 512'(16'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
